mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/mmio_uart_tx.sv | 164 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// ============================================================================
// Module : mmio_pkg
// Brief  : Shared constants, baud divisor helper and FSM state type for the
//          memory-mapped UART transmitter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

    localparam logic [31:0] TX_ADDR    = 32'hFFFF_0000;
    localparam int          CLK_HZ     = 100_000_000;
    localparam int          BAUD       = 115200;
    localparam int          FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Cycles per serial bit; integer truncation is intended.
    function automatic int calc_divisor(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    localparam int DIVISOR = calc_divisor(CLK_HZ, BAUD);

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with show-ahead read data; a push into a full
//          FIFO is accepted only when a pop happens in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int          AW         = $clog2(DEPTH);
    localparam int          CW         = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == FULL_COUNT);
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
// ============================================================================
// Module : mmio_uart_tx
// Brief  : Store-mapped UART transmitter: byte stores to TX_ADDR are queued in
//          a FIFO and serialised as 8N1 frames on a registered tx line.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mmio_uart_tx #(
    parameter logic [31:0] TX_ADDR    = mmio_pkg::TX_ADDR,
    parameter int          CLK_HZ     = mmio_pkg::CLK_HZ,
    parameter int          BAUD       = mmio_pkg::BAUD,
    parameter int          FIFO_DEPTH = mmio_pkg::FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value_from_alu,
    input  logic [31:0] data_to_write,
    input  logic        writting_to_mem,
    output logic        tx,
    output logic        fifo_full,
    output logic        tx_busy,
    output logic        overflow
);

    import mmio_pkg::*;

    localparam int BAUD_DIV = calc_divisor(CLK_HZ, BAUD);
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    uart_state_t      r_state;
    uart_state_t      w_next_state;
    logic             r_tx;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_overflow;

    logic             w_hit;
    logic             w_push;
    logic             w_pop;
    logic             w_bit_done;
    logic             w_tx_next;
    logic             w_shift_en;
    logic [7:0]       w_fifo_dout;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_unused_data;

    assign w_hit         = writting_to_mem && (value_from_alu == TX_ADDR);
    assign w_push        = w_hit && (!w_fifo_full || w_pop);
    assign w_bit_done    = (r_baud_cnt == CNT_LAST);
    assign w_unused_data = ^data_to_write[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (data_to_write[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!w_fifo_empty)                   w_next_state = START;
            START:   if (w_bit_done)                      w_next_state = DATA;
            DATA:    if (w_bit_done && r_bit_idx == 3'd7) w_next_state = STOP;
            STOP:    if (w_bit_done)                      w_next_state = IDLE;
            default:                                      w_next_state = IDLE;
        endcase
    end

    // w_tx_next is the line level for the cycle after this edge, so the
    // registered tx lines up exactly with the state it belongs to.
    always_comb begin
        w_pop      = 1'b0;
        w_shift_en = 1'b0;
        w_tx_next  = r_tx;
        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop     = 1'b1;
                    w_tx_next = 1'b0;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_tx_next = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_shift_en = 1'b1;
                    w_tx_next  = (r_bit_idx == 3'd7) ? 1'b1 : r_shift[1];
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    w_tx_next = 1'b1;
                end
            end
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_tx <= w_tx_next;

            if (r_state == IDLE || w_bit_done) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + CNT_W'(1);
            end

            if (w_pop) begin
                r_shift <= w_fifo_dout;
            end else if (w_shift_en) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end

            if (w_pop) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_hit && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign tx        = r_tx;
    assign fifo_full = w_fifo_full;
    assign tx_busy   = (r_state != IDLE) || !w_fifo_empty;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// ============================================================================
// Module : tb_mmio_uart_tx
// Brief  : Self-checking bench: frame-level reference model plus directed
//          stimulus with hand-computed expectations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmio_uart_tx;

    localparam int          D     = 868;
    localparam int          DEPTH = 8;
    localparam logic [31:0] ADDR  = 32'hFFFF_0000;

    localparam logic [3:0] M_TX   = 4'b1000;
    localparam logic [3:0] M_FULL = 4'b0100;
    localparam logic [3:0] M_BUSY = 4'b0010;
    localparam logic [3:0] M_OVF  = 4'b0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value_from_alu;
    logic [31:0] data_to_write;
    logic        writting_to_mem;
    logic        tx;
    logic        fifo_full;
    logic        tx_busy;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mmio_uart_tx dut (
        .clk             (clk),
        .reset           (reset),
        .value_from_alu  (value_from_alu),
        .data_to_write   (data_to_write),
        .writting_to_mem (writting_to_mem),
        .tx              (tx),
        .fifo_full       (fifo_full),
        .tx_busy         (tx_busy),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a byte queue and a frame position counter.
    byte unsigned m_q[$];
    bit           m_active = 1'b0;
    bit           m_ovf    = 1'b0;
    bit           m_valid  = 1'b0;
    int           m_pos    = 0;
    byte unsigned m_byte   = 8'h00;

    function automatic logic m_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_pos / D;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    always @(posedge clk) begin
        bit hit;
        bit was_full;
        bit pop;
        if (reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            hit      = writting_to_mem && (value_from_alu == ADDR);
            was_full = (m_q.size() == DEPTH);
            pop      = !m_active && (m_q.size() != 0);
            if (m_active) begin
                m_pos++;
                if (m_pos == 10*D) m_active = 1'b0;
            end
            if (pop) begin
                m_byte   = m_q.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end
            if (hit) begin
                if (!was_full || pop) m_q.push_back(data_to_write[7:0]);
                else                  m_ovf = 1'b1;
            end
        end
    end

    // Hand-computed expectations scheduled per cycle, checked by the compare process.
    typedef struct {
        logic [3:0] mask;
        logic [3:0] val;
        string      name;
    } lit_t;
    lit_t lit[int];

    task automatic expect_now(input string name, input logic [3:0] mask, input logic [3:0] val);
        lit_t e;
        if (lit.exists(cyc)) begin
            e = lit[cyc];
        end else begin
            e.mask = '0;
            e.val  = '0;
            e.name = "";
        end
        e.mask = e.mask | mask;
        e.val  = (e.val & ~mask) | (val & mask);
        e.name = {e.name, " ", name};
        lit[cyc] = e;
    endtask

    always @(negedge clk) begin
        logic [3:0] act;
        logic [3:0] exp;
        if (m_valid) begin
            act = {tx, fifo_full, tx_busy, overflow};
            exp = {m_tx(), (m_q.size() == DEPTH), (m_active || m_q.size() != 0), m_ovf};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL model cycle %0d {tx,full,busy,ovf}: got %b required %b", cyc, act, exp);
            end
            if (lit.exists(cyc)) begin
                total++;
                if (((act ^ lit[cyc].val) & lit[cyc].mask) != 4'b0 || $isunknown(act & lit[cyc].mask)) begin
                    bad++;
                    $display("FAIL literal%s cycle %0d {tx,full,busy,ovf}: got %b required %b mask %b",
                             lit[cyc].name, cyc, act, lit[cyc].val, lit[cyc].mask);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic we);
        value_from_alu  = a;
        data_to_write   = d;
        writting_to_mem = we;
        step(1);
        writting_to_mem = 1'b0;
    endtask

    initial begin
        // Reset with a simultaneous store hit: the hit must be ignored.
        reset           = 1'b1;
        writting_to_mem = 1'b1;
        value_from_alu  = ADDR;
        data_to_write   = 32'h0000_0077;
        step(3);
        reset           = 1'b0;
        writting_to_mem = 1'b0;
        expect_now("reset_state", 4'b1111, 4'b1000);
        step(1);
        expect_now("reset_hit_ignored", M_TX | M_BUSY, 4'b1000);

        // Single byte 0x55 (data word 0x155).
        store(ADDR, 32'h0000_0155, 1'b1);
        expect_now("n1_still_idle_busy", M_TX | M_BUSY, 4'b1010);
        step(1);
        expect_now("start_first", M_TX, 4'b0000);
        step(867);
        expect_now("start_last", M_TX, 4'b0000);
        step(1);
        expect_now("bit0_is_1", M_TX, 4'b1000);
        step(868);
        expect_now("bit1_is_0", M_TX, 4'b0000);
        step(6076);
        expect_now("stop_first", M_TX | M_BUSY, 4'b1010);
        step(867);
        expect_now("stop_last", M_TX | M_BUSY, 4'b1010);
        step(1);
        expect_now("idle_after_frame", M_TX | M_BUSY, 4'b1000);

        // Non-hit stores.
        store(32'hFFFF_0004, 32'h0000_0055, 1'b1);
        store(ADDR, 32'h0000_0066, 1'b0);
        step(3);
        expect_now("nonhit_no_effect", 4'b1111, 4'b1000);

        // Ten back-to-back hits: one popped, eight queued, tenth dropped.
        for (int i = 0; i < 10; i++) store(ADDR, i, 1'b1);
        expect_now("burst_full_ovf", M_FULL | M_OVF | M_BUSY, 4'b0111);
        step(860);
        expect_now("byte00_bit0", M_TX, 4'b0000);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        expect_now("reset_clears_burst", 4'b1111, 4'b1000);

        // Nine hits fill the FIFO; a tenth lands in the pop cycle after frame 0x10.
        for (int i = 0; i < 9; i++) store(ADDR, 32'h10 + i, 1'b1);
        expect_now("fill_full_no_ovf", M_FULL | M_OVF, 4'b0100);
        step(8673);
        store(ADDR, 32'h0000_0019, 1'b1);
        expect_now("pop_push_accepted", M_TX | M_FULL | M_OVF, 4'b0100);

        // Reset in the middle of the data bits of frame 0x11 with bytes queued.
        step(3472);
        expect_now("byte11_bit3", M_TX, 4'b0000);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        expect_now("midframe_reset", 4'b1111, 4'b1000);
        step(2000);
        expect_now("no_frames_after_reset", M_TX | M_BUSY, 4'b1000);

        // Two back-to-back bytes: frames separated by one idle cycle.
        store(ADDR, 32'h0000_00A5, 1'b1);
        store(ADDR, 32'h0000_003C, 1'b1);
        expect_now("a5_start", M_TX, 4'b0000);
        step(8679);
        expect_now("a5_stop_last", M_TX, 4'b1000);
        step(1);
        expect_now("gap_cycle", M_TX | M_BUSY, 4'b1010);
        step(1);
        expect_now("3c_start", M_TX, 4'b0000);
        step(8679);
        expect_now("3c_stop_last", M_TX | M_BUSY, 4'b1010);
        step(1);
        expect_now("pair_done", M_TX | M_BUSY, 4'b1000);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
